frost32_mem_access_unit: RTL

// - Load/store unit between the Frost32 CPU memory port and a word-wide ack-based memory bus.
// - Accepts one request (addr, 32/16/8 size, read/write, signed), checks alignment and size.
// - Drives byte lanes, waits on bus_ack with a timeout, returns a sign/zero-extended result.
// - Generalises the fixed 32-bit CPU port to DATA_WIDTH-wide buses with error reporting.
//

---
 rtl/frost32_mem_access_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/frost32_mem_access_unit.sv
// Frost32 load/store unit: validates a CPU memory request, runs one word-wide
// ack-based bus transaction with timeout, and returns an extended load result.
module frost32_mem_access_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      req_write,
  input  logic [1:0]                req_size,
  input  logic                      req_signed,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               rdata,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic                      bus_req,
  output logic                      bus_write,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [DATA_WIDTH/8-1:0]   bus_byte_en,
  output logic [DATA_WIDTH-1:0]     bus_wdata,
  input  logic [DATA_WIDTH-1:0]     bus_rdata,
  input  logic                      bus_ack
);

  localparam int unsigned LANES     = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(LANES);
  localparam int unsigned CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t                 state_q;
  logic                   done_q;
  logic [31:0]            rdata_q;
  logic                   err_q;
  logic [1:0]             err_code_q;
  logic                   bus_req_q;
  logic                   bus_write_q;
  logic [ADDR_WIDTH-1:0]  bus_addr_q;
  logic [LANES-1:0]       bus_byte_en_q;
  logic [DATA_WIDTH-1:0]  bus_wdata_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [1:0]             size_q;
  logic [LANE_BITS-1:0]   lane_q;
  logic                   signed_q;

  logic [LANE_BITS-1:0]   lane_d;
  logic [LANES-1:0]       be_base_d;
  logic [LANES-1:0]       be_d;
  logic [31:0]            wdata_m_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [ADDR_WIDTH-1:0]  bus_addr_d;
  logic                   misalign_d;
  logic [DATA_WIDTH-1:0]  rd_shift_d;
  logic [31:0]            rd_ext_d;
  logic                   timeout_hit_d;

  assign lane_d     = req_addr[LANE_BITS-1:0];
  assign bus_addr_d = {req_addr[ADDR_WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
  assign misalign_d = ((req_size == 2'd0) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'd1) && req_addr[0]);

  always_comb begin
    be_base_d = LANES'(1);
    wdata_m_d = {24'b0, req_wdata[7:0]};
    case (req_size)
      2'd0: begin
        be_base_d = LANES'(4'hF);
        wdata_m_d = req_wdata;
      end
      2'd1: begin
        be_base_d = LANES'(2'h3);
        wdata_m_d = {16'b0, req_wdata[15:0]};
      end
      default: ;
    endcase
  end

  assign be_d    = be_base_d << lane_d;
  assign wdata_d = DATA_WIDTH'(wdata_m_d) << {lane_d, 3'b000};

  // Load data is extracted from the lane latched at request time, not the live address.
  assign rd_shift_d = bus_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    rd_ext_d = rd_shift_d[31:0];
      2'd1:    rd_ext_d = {{16{signed_q & rd_shift_d[15]}}, rd_shift_d[15:0]};
      default: rd_ext_d = {{24{signed_q & rd_shift_d[7]}}, rd_shift_d[7:0]};
    endcase
  end

  assign timeout_hit_d = (TIMEOUT_CYCLES != 0) &&
                         ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      bus_req_q     <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_addr_q    <= '0;
      bus_byte_en_q <= '0;
      bus_wdata_q   <= '0;
      cnt_q         <= '0;
      size_q        <= '0;
      lane_q        <= '0;
      signed_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (req_size == 2'd3) begin
              state_q    <= ST_RESP;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
              rdata_q    <= '0;
            end else if (misalign_d) begin
              state_q    <= ST_RESP;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
              rdata_q    <= '0;
            end else begin
              state_q       <= ST_BUS;
              bus_req_q     <= 1'b1;
              bus_write_q   <= req_write;
              bus_addr_q    <= bus_addr_d;
              bus_byte_en_q <= be_d;
              bus_wdata_q   <= wdata_d;
              cnt_q         <= '0;
              size_q        <= req_size;
              lane_q        <= lane_d;
              signed_q      <= req_signed;
            end
          end
        end
        ST_BUS: begin
          // An ack on the edge where the timeout would fire takes priority.
          if (bus_ack) begin
            state_q    <= ST_RESP;
            done_q     <= 1'b1;
            bus_req_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            rdata_q    <= bus_write_q ? 32'd0 : rd_ext_d;
          end else if (timeout_hit_d) begin
            state_q    <= ST_RESP;
            done_q     <= 1'b1;
            bus_req_q  <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
            rdata_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign bus_req     = bus_req_q;
  assign bus_write   = bus_write_q;
  assign bus_addr    = bus_addr_q;
  assign bus_byte_en = bus_byte_en_q;
  assign bus_wdata   = bus_wdata_q;

endmodule
